// File: rtl/c_wdemux.sv
// Write-side demux for the CONV result stream: steers beats into feature RAM1/RAM2 through one
// registered stage, generating auto-incremented addresses from a latched base and masking idle lanes.
module c_wdemux #(
   parameter int unsigned DW  = 8,
   parameter int unsigned DN  = 8,
   parameter int unsigned AW  = 14,
   parameter int unsigned IFW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               w_start,
   input  logic [IFW-1:0]     winfo,
   input  logic [AW-1:0]      w_base,
   input  logic [DN*DW-1:0]   m_data,
   input  logic               m_data_first,
   input  logic               m_data_last,
   input  logic               m_data_valid,
   output logic               m_data_ready,
   output logic [AW-1:0]      s_addr,
   output logic [DN*DW-1:0]   s_data,
   output logic [DN-1:0]      s_wmask,
   output logic               s_data_first,
   output logic               s_data_last,
   output logic               s_data_valid1,
   input  logic               s_data_ready1,
   output logic               s_data_valid2,
   input  logic               s_data_ready2,
   output logic               busy,
   output logic               done
);

   localparam int unsigned BW = DN * DW;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic            sel_q, sel_d;
   logic [AW-1:0]   base_q, base_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            ovld_q, ovld_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [BW-1:0]   data_q, data_d;
   logic [DN-1:0]   wmask_q, wmask_d;
   logic            first_q, first_d;
   logic            last_q, last_d;
   logic            done_q, done_d;

   logic            rdy_sel_c;
   logic            accept_c;
   logic [AW-1:0]   idx_c;
   logic [DN-1:0]   lane_mask_c;
   logic [BW-1:0]   data_m_c;
   logic            unused_winfo;

   assign unused_winfo = ^{winfo[4], winfo[2:0]};

   assign rdy_sel_c    = sel_q ? s_data_ready2 : s_data_ready1;
   assign m_data_ready = (state_q == ST_RUN) && (!ovld_q || rdy_sel_c);
   assign accept_c     = m_data_ready && m_data_valid;
   // A first beat mid-packet restarts addressing at the base.
   assign idx_c        = m_data_first ? '0 : cnt_q;

   // Lane enables from the active channel count (0 means all lanes).
   always_comb begin
      lane_mask_c = '0;
      data_m_c    = '0;
      for (int i = 0; i < int'(DN); i++) begin
         lane_mask_c[i] = (ch_q == '0) || (i < int'(ch_q));
         data_m_c[i*DW +: DW] = lane_mask_c[i] ? m_data[i*DW +: DW] : '0;
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      sel_d   = sel_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      ovld_d  = ovld_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wmask_d = wmask_q;
      first_d = first_q;
      last_d  = last_q;
      done_d  = 1'b0;

      if (ovld_q && rdy_sel_c) ovld_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_start && !done_q) begin
               ch_d    = winfo[7:5];
               sel_d   = winfo[3];
               base_d  = w_base;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept_c) begin
               addr_d  = base_q + idx_c;
               cnt_d   = idx_c + AW'(1);
               data_d  = data_m_c;
               wmask_d = lane_mask_c;
               first_d = m_data_first;
               last_d  = m_data_last;
               ovld_d  = 1'b1;
               if (m_data_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!ovld_q || rdy_sel_c) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         sel_q   <= 1'b0;
         base_q  <= '0;
         cnt_q   <= '0;
         ovld_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         wmask_q <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         sel_q   <= sel_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         ovld_q  <= ovld_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wmask_q <= wmask_d;
         first_q <= first_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign s_addr        = addr_q;
   assign s_data        = data_q;
   assign s_wmask       = wmask_q;
   assign s_data_first  = first_q;
   assign s_data_last   = last_q;
   assign s_data_valid1 = ovld_q && !sel_q;
   assign s_data_valid2 = ovld_q && sel_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;

endmodule

// File: tb/tb_c_wdemux.sv
// Directed bench for c_wdemux: address generation, lane masking, ping-pong steering, stalls and reset.
module tb_c_wdemux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        w_start;
   logic [7:0]  winfo;
   logic [13:0] w_base;
   logic [63:0] m_data;
   logic        m_data_first, m_data_last, m_data_valid, m_data_ready;
   logic [13:0] s_addr;
   logic [63:0] s_data;
   logic [7:0]  s_wmask;
   logic        s_data_first, s_data_last;
   logic        s_data_valid1, s_data_ready1, s_data_valid2, s_data_ready2;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wr_cyc = 0;
   int done_cnt = 0;
   int v2_cnt = 0;
   int both_err = 0;
   logic [13:0] wa_q[$];
   logic [63:0] wd_q[$];
   logic [7:0]  wm_q[$];
   int          wr_q[$];

   c_wdemux dut (
      .clk(clk), .rst_n(rst_n), .w_start(w_start), .winfo(winfo), .w_base(w_base),
      .m_data(m_data), .m_data_first(m_data_first), .m_data_last(m_data_last),
      .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
      .s_addr(s_addr), .s_data(s_data), .s_wmask(s_wmask),
      .s_data_first(s_data_first), .s_data_last(s_data_last),
      .s_data_valid1(s_data_valid1), .s_data_ready1(s_data_ready1),
      .s_data_valid2(s_data_valid2), .s_data_ready2(s_data_ready2),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor: a write completes at the edge following a valid&ready negedge sample.
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_data_valid1 && s_data_valid2) both_err++;
         if (s_data_valid2) v2_cnt++;
         if ((s_data_valid1 && s_data_ready1) || (s_data_valid2 && s_data_ready2)) begin
            wa_q.push_back(s_addr);
            wd_q.push_back(s_data);
            wm_q.push_back(s_wmask);
            wr_q.push_back(s_data_valid2 ? 2 : 1);
            last_wr_cyc = cyc;
         end
         if (done) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_wr();
      wa_q.delete(); wd_q.delete(); wm_q.delete(); wr_q.delete();
   endtask

   task automatic start_pkt(input logic [7:0] info, input logic [13:0] base);
      w_start = 1'b1; winfo = info; w_base = base;
      tick();
      w_start = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic f, input logic l);
      bit ok = 1'b0;
      m_data = d; m_data_first = f; m_data_last = l; m_data_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m_data_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("beat_accept_timeout", 64'(ok), 64'd1);
      tick();
      m_data_valid = 1'b0; m_data_first = 1'b0; m_data_last = 1'b0;
   endtask

   // Returns at the negedge of the done cycle.
   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) chk({tag, "_done_lat"}, 64'(cyc - last_wr_cyc), 64'd1);
   endtask

   task automatic expect_wr(input string tag, input int idx, input logic [13:0] a,
                            input logic [63:0] d, input logic [7:0] m, input int ram);
      if (idx >= wa_q.size()) begin
         chk({tag, "_present"}, 64'(wa_q.size()), 64'(idx + 1));
      end else begin
         chk({tag, "_addr"}, 64'(wa_q[idx]), 64'(a));
         chk({tag, "_data"}, wd_q[idx], d);
         chk({tag, "_mask"}, 64'(wm_q[idx]), 64'(m));
         chk({tag, "_ram"}, 64'(wr_q[idx]), 64'(ram));
      end
   endtask

   function automatic logic [63:0] pat(input int k);
      return {8{8'(k)}};
   endfunction

   initial begin
      int v2_base;
      int done_base;
      bit stable;
      logic [13:0] exp_a;

      rst_n = 1'b0; w_start = 1'b0; winfo = '0; w_base = '0; m_data = '0;
      m_data_first = 1'b0; m_data_last = 1'b0; m_data_valid = 1'b0;
      s_data_ready1 = 1'b0; s_data_ready2 = 1'b0;
      tick(); tick();
      chk("reset_outputs", {m_data_ready, s_addr, s_wmask, s_data_first, s_data_last,
                            s_data_valid1, s_data_valid2, busy, done}, 64'd0);
      chk("reset_data", s_data, 64'd0);
      rst_n = 1'b1;
      tick();

      // Test 1: RAM1, all lanes, base 0x100
      s_data_ready1 = 1'b1; s_data_ready2 = 1'b0;
      clear_wr(); v2_base = v2_cnt;
      start_pkt(8'h00, 14'h100);
      chk("t1_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) send_beat(pat(16 + i), i == 0, i == 3);
      wait_done("t1");
      tick();
      chk("t1_count", 64'(wa_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) expect_wr("t1_wr", i, 14'h100 + 14'(i), pat(16 + i), 8'hFF, 1);
      chk("t1_no_valid2", 64'(v2_cnt - v2_base), 64'd0);
      chk("t1_idle", 64'(busy), 64'd0);

      // Test 2: RAM2, three channels; w_start during done is ignored
      s_data_ready1 = 1'b0; s_data_ready2 = 1'b1;
      clear_wr();
      start_pkt(8'h68, 14'h0AB);
      send_beat(64'h0807060504030201, 1'b1, 1'b1);
      wait_done("t2");
      w_start = 1'b1; winfo = 8'h00; w_base = 14'h111;
      tick();
      w_start = 1'b0;
      chk("t2_start_on_done_ignored", 64'(busy), 64'd0);
      chk("t2_count", 64'(wa_q.size()), 64'd1);
      expect_wr("t2_wr", 0, 14'h0AB, 64'h0000000000030201, 8'h07, 2);

      // Test 3: RAM1 stalls for 5 cycles mid-packet
      s_data_ready1 = 1'b1; s_data_ready2 = 1'b0;
      clear_wr();
      start_pkt(8'h00, 14'h200);
      for (int i = 0; i < 3; i++) send_beat(pat(32 + i), i == 0, 1'b0);
      s_data_ready1 = 1'b0;
      m_data = pat(35); m_data_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (m_data_ready || s_addr !== 14'h202 || s_data !== pat(34) || !s_data_valid1)
            stable = 1'b0;
      end
      chk("t3_stall_hold", 64'(stable), 64'd1);
      tick();
      s_data_ready1 = 1'b1;
      for (int i = 3; i < 6; i++) send_beat(pat(32 + i), 1'b0, i == 5);
      wait_done("t3");
      tick();
      chk("t3_count", 64'(wa_q.size()), 64'd6);
      for (int i = 0; i < 6; i++) expect_wr("t3_wr", i, 14'h200 + 14'(i), pat(32 + i), 8'hFF, 1);

      // Test 4: address wrap
      clear_wr();
      start_pkt(8'h00, 14'h3FFE);
      for (int i = 0; i < 4; i++) send_beat(pat(48 + i), i == 0, i == 3);
      wait_done("t4");
      tick();
      exp_a = 14'h3FFE;
      for (int i = 0; i < 4; i++) begin
         expect_wr("t4_wr", i, exp_a, pat(48 + i), 8'hFF, 1);
         exp_a = exp_a + 14'd1;
      end

      // Test 5: second first beat restarts addressing; w_start while busy ignored
      clear_wr();
      start_pkt(8'h00, 14'h020);
      send_beat(pat(64), 1'b1, 1'b0);
      send_beat(pat(65), 1'b0, 1'b0);
      w_start = 1'b1; winfo = 8'h08; w_base = 14'h300;
      tick();
      w_start = 1'b0;
      send_beat(pat(66), 1'b1, 1'b0);
      send_beat(pat(67), 1'b0, 1'b0);
      send_beat(pat(68), 1'b0, 1'b1);
      wait_done("t5");
      tick();
      chk("t5_count", 64'(wa_q.size()), 64'd5);
      expect_wr("t5_wr0", 0, 14'h020, pat(64), 8'hFF, 1);
      expect_wr("t5_wr1", 1, 14'h021, pat(65), 8'hFF, 1);
      expect_wr("t5_wr2", 2, 14'h020, pat(66), 8'hFF, 1);
      expect_wr("t5_wr3", 3, 14'h021, pat(67), 8'hFF, 1);
      expect_wr("t5_wr4", 4, 14'h022, pat(68), 8'hFF, 1);

      // Test 6: reset mid-packet with the stage full
      s_data_ready1 = 1'b0;
      clear_wr();
      start_pkt(8'h00, 14'h040);
      send_beat(pat(80), 1'b1, 1'b0);
      chk("t6_stage_full", 64'(s_data_valid1), 64'd1);
      done_base = done_cnt;
      rst_n = 1'b0;
      tick();
      chk("t6_reset_outputs", {m_data_ready, s_addr, s_wmask, s_data_first, s_data_last,
                               s_data_valid1, s_data_valid2, busy, done}, 64'd0);
      chk("t6_reset_data", s_data, 64'd0);
      rst_n = 1'b1;
      s_data_ready1 = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_no_done", 64'(done_cnt - done_base), 64'd0);
      chk("t6_no_write", 64'(wa_q.size()), 64'd0);

      chk("total_done_pulses", 64'(done_cnt), 64'd5);
      chk("valid_exclusive", 64'(both_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
